input_buffer_ctrl: RTL and testbench

INPUT_BUFFER_CTRL -- requirements
Module: input_buffer_ctrl

---
 rtl/input_buffer_ctrl.sv | 97 +++++++++
 tb/tb_input_buffer_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_ctrl.sv
// Router input-port controller: tracks an external flit RAM, parses packets and issues route requests.
// Latency: a flit written at edge t is at the front from cycle t+1; route request one cycle later.
// Backpressure: in_ready_o drops at DEPTH flits; front flit held while out_ready_i is low; credit per pop.
module input_buffer_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 5,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  ram_wenable_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  route_req_o,
    input  logic                  route_grant_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  credit_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  protocol_err_o
);
    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  err;
    logic [1:0]            front_type;
    logic                  empty;
    logic                  front_is_head;
    logic                  front_is_last;
    logic                  push;
    logic                  pop;
    logic                  idle_drop;
    logic                  payload_unused;

    assign payload_unused = ^ram_rdata_i[DATA_WIDTH-3:0];

    // Type bit 1 marks a packet start (head, head+tail); bit 0 marks a packet end (tail, head+tail).
    assign front_type    = ram_rdata_i[DATA_WIDTH-1 -: 2];
    assign front_is_head = front_type[1];
    assign front_is_last = front_type[0];
    assign empty         = (count == '0);

    assign in_ready_o  = (count < FULL_CNT);
    assign push        = in_valid_i & in_ready_o & ~reset;
    assign out_valid_o = (state == ACTIVE) & ~empty & ~reset;
    assign idle_drop   = (state == IDLE) & ~empty & ~front_is_head & ~reset;
    assign pop         = idle_drop | (out_valid_o & out_ready_i);

    assign ram_wenable_o  = push;
    assign ram_waddr_o    = wr_ptr;
    assign ram_raddr_o    = rd_ptr;
    assign route_req_o    = (state == ROUTE) & ~reset;
    assign credit_o       = pop;
    assign count_o        = count;
    assign protocol_err_o = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (idle_drop) begin
                err <= 1'b1;
            end
            case (state)
                IDLE:    if (!empty && front_is_head) state <= ROUTE;
                ROUTE:   if (route_grant_i) state <= ACTIVE;
                ACTIVE:  if (pop && front_is_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Bench for input_buffer_ctrl: flit RAM model, packet-stream scoreboard, directed and random traffic.
module tb_input_buffer_ctrl;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 5;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct {
        logic [DW-1:0] data;
        bit            deliver;
        bit            first;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          ram_wenable;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          route_req;
    logic          route_grant;
    logic          out_valid;
    logic          out_ready;
    logic          credit;
    logic [CW-1:0] count;
    logic          protocol_err;

    logic [DW-1:0] mem [2**AW];
    ev_t           q[$];
    int            errors = 0;
    int            checks = 0;
    int            wr_idx = 0;
    int            rd_idx = 0;
    bit            in_pkt = 0;
    bit            err_exp = 0;
    int            n_credit = 0;
    int            n_deliv = 0;
    int            grant_mode = 0;

    always #5 clk = ~clk;

    input_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .ram_wenable_o(ram_wenable), .ram_waddr_o(ram_waddr),
        .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
        .route_req_o(route_req), .route_grant_i(route_grant),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .credit_o(credit), .count_o(count), .protocol_err_o(protocol_err)
    );

    initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    always @(posedge clk) if (ram_wenable) mem[ram_waddr] <= in_data;
    assign ram_rdata = mem[ram_raddr];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: each accepted flit is classified from the packet stream seen so far;
    // each credit pops the oldest entry and must match it.
    always @(negedge clk) begin : monitor
        ev_t e;
        ev_t p;
        logic [1:0] t;
        if (!reset) begin
            chk("count", count, q.size());
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("protocol_err", protocol_err, err_exp);
        end else begin
            chk("rst_credit", credit, 0);
            chk("rst_route_req", route_req, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        chk("wenable", ram_wenable, in_valid && !reset && q.size() < DEPTH);
        if (out_valid) chk("valid_front_deliver", q.size() > 0 && q[0].deliver, 1);
        if (route_req) begin
            chk("req_front_head", q.size() > 0 && q[0].first, 1);
            chk("req_no_pop", credit, 0);
        end
        if (credit) begin
            n_credit++;
            if (q.size() == 0) begin
                chk("credit_when_empty", credit, 0);
            end else begin
                p = q.pop_front();
                chk("raddr", ram_raddr, rd_idx);
                chk("pop_data", ram_rdata, p.data);
                chk("pop_kind", out_valid && out_ready, p.deliver);
                rd_idx = (rd_idx + 1) % DEPTH;
                if (p.deliver) n_deliv++;
                else err_exp = 1;
            end
        end else if (out_valid && out_ready) begin
            chk("accept_without_credit", credit, 1);
        end
        if (ram_wenable) begin
            chk("waddr", ram_waddr, wr_idx);
            wr_idx = (wr_idx + 1) % DEPTH;
            t = in_data[DW-1 -: 2];
            e.data = in_data;
            if (!in_pkt) begin
                e.first = (t == 2'b10 || t == 2'b11);
                e.deliver = e.first;
                in_pkt = (t == 2'b10);
            end else begin
                e.first = 0;
                e.deliver = 1;
                if (t == 2'b01 || t == 2'b11) in_pkt = 0;
            end
            q.push_back(e);
        end
        if (reset) begin
            q.delete();
            wr_idx = 0;
            rd_idx = 0;
            in_pkt = 0;
            err_exp = 0;
        end
    end

    task automatic step();
        logic prev_req;
        prev_req = route_req;
        @(posedge clk);
        #1;
        if (grant_mode == 1) route_grant = prev_req;
        else if (grant_mode == 2) route_grant = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1;
        in_data = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", in_ready, 1);
        step();
        in_valid = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        int c0;
        int d0;
        int ra;
        int wa;
        reset = 1; in_valid = 0; in_data = '0; out_ready = 0; route_grant = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("reset_count", count, 0);
        chk("reset_ready", in_ready, 1);
        chk("reset_err", protocol_err, 0);

        // Single three-flit packet, grant one cycle after request.
        grant_mode = 1; out_ready = 1;
        c0 = n_credit; d0 = n_deliv;
        send(16'h8001); send(16'h0002); send(16'h4003);
        drain(40);
        chk("pkt_credits", n_credit - c0, 3);
        chk("pkt_delivered", n_deliv - d0, 3);
        step();
        chk("pkt_idle_req", route_req, 0);
        chk("pkt_idle_valid", out_valid, 0);

        // Fill to DEPTH with downstream stalled, then free one slot.
        out_ready = 0;
        send(16'h8004);
        for (int i = 0; i < 4; i++) send(16'h0010 + 16'(i));
        step();
        chk("fill_count", count, DEPTH);
        chk("fill_ready", in_ready, 0);
        in_valid = 1; in_data = 16'h0006;
        step();
        in_valid = 0;
        chk("fill_sixth_ignored", count, DEPTH);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("fill_ready_after_pop", in_ready, 1);
        chk("fill_count_after_pop", count, DEPTH - 1);
        out_ready = 1;
        send(16'h4007);
        drain(60);

        // Twelve single-flit packets with the grant held high.
        grant_mode = 0; route_grant = 1;
        c0 = n_credit; d0 = n_deliv;
        for (int n = 0; n < 12; n++) send(16'hC000 | 16'(n));
        drain(100);
        chk("wrap_credits", n_credit - c0, 12);
        chk("wrap_delivered", n_deliv - d0, 12);

        // Simultaneous push and pop at occupancy 3.
        out_ready = 0;
        send(16'h8020); send(16'h0021); send(16'h0022);
        repeat (3) step();
        chk("sim_active", out_valid, 1);
        chk("sim_count_before", count, 3);
        ra = ram_raddr; wa = ram_waddr;
        in_valid = 1; in_data = 16'h0023; out_ready = 1;
        step();
        in_valid = 0; out_ready = 0;
        chk("sim_count_after", count, 3);
        chk("sim_raddr", ram_raddr, (ra + 1) % DEPTH);
        chk("sim_waddr", ram_waddr, (wa + 1) % DEPTH);
        out_ready = 1;
        send(16'h4024);
        drain(40);

        // Stray body flit into an idle buffer.
        c0 = n_credit;
        send(16'h0005);
        repeat (3) step();
        chk("perr_credit", n_credit - c0, 1);
        chk("perr_flag", protocol_err, 1);
        chk("perr_count", count, 0);
        repeat (5) step();
        chk("perr_sticky", protocol_err, 1);

        // Reset in the middle of a packet.
        out_ready = 0;
        send(16'h8011); send(16'h0012);
        repeat (3) step();
        chk("mid_active", out_valid, 1);
        chk("mid_count", count, 2);
        c0 = n_credit;
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_err", protocol_err, 0);
        chk("mid_rst_credit", n_credit - c0, 0);
        step();
        chk("mid_rst_req", route_req, 0);
        chk("mid_rst_valid", out_valid, 0);

        // Random traffic with random types, stalls, grants and occasional resets.
        grant_mode = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            r = $urandom_range(0, 9);
            in_valid = ($urandom_range(0, 1) == 1);
            in_data[DW-3:0] = 14'($urandom);
            in_data[DW-1 -: 2] = (r < 3) ? 2'b10 : (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : 2'b11;
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 0; in_valid = 0; out_ready = 1;
        grant_mode = 0; route_grant = 1;
        drain(200);
        step();
        chk("final_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
